alu_issue_ctrl: RTL
===================

# alu_issue_ctrl

Sequencing front end that drives the shared 32-bit combinational ALU, acting as the initiator on the ALU's operand/selector/result interface. Accepts one operation request at a time over a valid/ready handshake and registers operands onto the ALU inputs. Samples the ALU result and flags after one execute cycle, then holds them on a valid/ready response port until the consumer takes them. Sits between the instruction decode/issue stage and the ALU.

## Interface
- No parameters; data width fixed at 32, opcode width 3, tag width 4.
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request
- req_op  in  3  ALU selector code (shared ALU header encodings: add, sub, and, or, xor, sll, slr, sar)
- req_a  in  32  operand A
- req_b  in  32  operand B (shift amount in bits [5:0] for shifts)
- req_tag  in  4  opaque ID, echoed on response
- req_fwd  in  1  replace operand A with last result (only active under ALU_ISSUE_FWD_EN)
- alu_in0  out  32  ALU operand 0
- alu_in1  out  32  ALU operand 1
- alu_sel  out  3  ALU selector
- alu_out0  in  32  ALU result
- alu_zero, alu_msb, alu_carry  in  1 each  ALU flags
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_data  out  32  captured result
- rsp_zero, rsp_msb, rsp_carry  out  1 each  captured flags
- rsp_tag  out  4  echoed tag
- busy  out  1  high whenever state is not IDLE

## Operation
- States: IDLE, EXEC, RESP. Reset state IDLE.
- IDLE: req_ready=1. On req_valid&&req_ready at an edge: latch req_op, req_a (or forwarded value), req_b, req_tag into operand registers; go EXEC.
- EXEC: alu_in0/alu_in1/alu_sel driven from operand registers (registered, stable whole cycle). At the closing edge capture alu_out0 -> rsp_data, alu_zero -> rsp_zero, alu_msb -> rsp_msb, tag -> rsp_tag; go RESP.
- rsp_carry = alu_carry when captured op is sub, else 0 (ALU carry is a borrow, meaningful only for sub).
- RESP: rsp_valid=1; all rsp_* stable until handshake. On rsp_valid&&rsp_ready: go IDLE. req_ready=0 in EXEC and RESP; requests there are ignored, not queued.
- Operands passed unmodified; no range check on shift amount (ALU interprets req_b[5:0]).
- alu_* outputs hold last operand values outside EXEC (no toggling while idle).

## Timing
- Reset values: req_ready=1 once rst deasserts (0 while rst high), rsp_valid=0, busy=0, rsp_data=0, rsp_zero/msb/carry=0, rsp_tag=0, alu_in0=alu_in1=0, alu_sel=0, last-result register=0.
- Accept at edge E0 -> EXEC cycle -> rsp_valid high after edge E1 (latency 2 edges accept-to-valid).
- With rsp_ready held high: handshake at E2, req_ready high after E2, next accept at E3 earliest. Throughput: 1 op / 3 cycles.
- rsp_ready low: RESP held indefinitely, data unchanged.
- rst asserted mid-EXEC or mid-RESP: immediate return to IDLE, in-flight result discarded, rsp_valid drops asynchronously; no response ever produced for that tag.
- rsp_ready high in IDLE/EXEC: no effect.

## Configuration
- ALU_ISSUE_FWD_EN defined: a last-result register updates with rsp_data at each response handshake; a request accepted with req_fwd=1 uses that register as operand A instead of req_a.
- Not defined: req_fwd ignored, no last-result register; operand A always req_a.

## Test plan
- Reset then add: a=0x0000_0005, b=0x0000_0003, tag=0x2 -> rsp_valid 2 edges after accept, rsp_data=0x8, zero=0, msb=0, carry=0, tag=0x2.
- Sub with borrow: a=0x1, b=0x2 -> rsp_data=0xFFFF_FFFF, msb=1, carry=1, zero=0; sub a=b=0x1234 -> rsp_data=0, zero=1, carry=0.
- Backpressure: xor result held with rsp_ready=0 for 5 cycles -> rsp_* unchanged, req_ready=0, second req_valid ignored; on rsp_ready=1, IDLE next edge.
- Shifts: sar a=0x8000_0000, b=4 -> 0xF800_0000, msb=1; slr same -> 0x0800_0000; carry=0 for both.
- Reset mid-RESP: assert rst with rsp_valid=1 -> rsp_valid=0, busy=0 immediately; after release, next request completes normally with its own tag.
- With ALU_ISSUE_FWD_EN: add 2+3 (result 5), then add req_fwd=1, req_a=0x99, b=0x10 -> rsp_data=0x15; without macro same stimulus -> 0xA9.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// Issue controller for the shared 32-bit combinational ALU: accepts one request, runs one execute cycle, holds the response.
// Optional macro ALU_ISSUE_FWD_EN adds a last-result register that can replace operand A.
module alu_issue_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [3:0]  req_tag,
  input  logic        req_fwd,
  output logic [31:0] alu_in0,
  output logic [31:0] alu_in1,
  output logic [2:0]  alu_sel,
  input  logic [31:0] alu_out0,
  input  logic        alu_zero,
  input  logic        alu_msb,
  input  logic        alu_carry,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_zero,
  output logic        rsp_msb,
  output logic        rsp_carry,
  output logic [3:0]  rsp_tag,
  output logic        busy
);

  localparam int unsigned DW  = 32;
  localparam int unsigned OPW = 3;
  localparam int unsigned TW  = 4;
  localparam logic [OPW-1:0] OP_SUB = OPW'(1);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t        state;
  state_t        state_next;
  logic          accept;
  logic          rsp_fire;
  logic [TW-1:0] tag_q;
  logic [DW-1:0] opa;

  // Operand A source: optional forwarding of the last handed-off result
`ifdef ALU_ISSUE_FWD_EN
  logic [DW-1:0] last_result;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_result <= '0;
    end else if (rsp_fire) begin
      last_result <= rsp_data;
    end
  end

  assign opa = req_fwd ? last_result : req_a;
`else
  logic unused_fwd;
  assign unused_fwd = req_fwd;
  assign opa        = req_a;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake decode
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    rsp_fire   = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid && req_ready) begin
          accept     = 1'b1;
          state_next = EXEC;
        end
      end
      EXEC: begin
        state_next = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_fire   = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Registered handshake/status outputs track the state being entered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      req_ready <= (state_next == IDLE);
      rsp_valid <= (state_next == RESP);
      busy      <= (state_next != IDLE);
    end
  end

  // ALU operand registers double as the request latch; they hold outside EXEC
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_in0 <= '0;
      alu_in1 <= '0;
      alu_sel <= '0;
      tag_q   <= '0;
    end else if (accept) begin
      alu_in0 <= opa;
      alu_in1 <= req_b;
      alu_sel <= req_op;
      tag_q   <= req_tag;
    end
  end

  // Response capture at the end of the execute cycle; carry is a borrow, kept only for sub
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_data  <= '0;
      rsp_zero  <= 1'b0;
      rsp_msb   <= 1'b0;
      rsp_carry <= 1'b0;
      rsp_tag   <= '0;
    end else if (state == EXEC) begin
      rsp_data  <= alu_out0;
      rsp_zero  <= alu_zero;
      rsp_msb   <= alu_msb;
      rsp_carry <= (alu_sel == OP_SUB) && alu_carry;
      rsp_tag   <= tag_q;
    end
  end

endmodule
